keypad_entry: RTL and testbench

KEYPAD_ENTRY -- requirements
Module: keypad_entry

---
 rtl/keypad_entry_pkg.sv | 33 +++
 rtl/keypad_entry_if.sv | 26 ++
 rtl/keypad_sync_debounce.sv | 132 +++++++++++++
 rtl/keypad_entry.sv | 52 +++++
 tb/tb_keypad_entry.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_entry_pkg.sv
// Shared types and helpers for the keypad digit-entry block.
package keypad_entry_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned KEY_N = 10;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } kp_state_e;

  typedef logic [KEY_N-1:0] key_code_t;
  typedef logic [BCD_W-1:0] bcd_t;

  typedef struct packed {
    bcd_t mins;
    bcd_t sec_tens;
    bcd_t sec_ones;
  } entry_time_t;

  // Key k maps to BCD k; callers guarantee a one-hot code.
  function automatic bcd_t onehot_to_bcd(input key_code_t code);
    bcd_t v;
    v = '0;
    for (int unsigned k = 0; k < KEY_N; k++) begin
      if (code[k]) v = BCD_W'(k);
    end
    return v;
  endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Keypad entry bus: raw key lines and controls in, accepted digit and entered time out.
interface keypad_entry_if;
  import keypad_entry_pkg::*;

  logic [KEY_N-1:0] keypad;
  logic             entry_en;
  logic             flush;
  logic [BCD_W-1:0] digit;
  logic             digit_valid;
  logic [BCD_W-1:0] mins;
  logic [BCD_W-1:0] sec_tens;
  logic [BCD_W-1:0] sec_ones;
  logic             time_nonzero;
  logic             time_ok;

  modport master (
    output keypad, entry_en, flush,
    input  digit, digit_valid, mins, sec_tens, sec_ones, time_nonzero, time_ok
  );

  modport slave (
    input  keypad, entry_en, flush,
    output digit, digit_valid, mins, sec_tens, sec_ones, time_nonzero, time_ok
  );

endinterface

// File: rtl/keypad_sync_debounce.sv
// Synchronizes raw key lines, debounces press/release and emits one accepted digit per press.
module keypad_sync_debounce
  import keypad_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 10
) (
  input  logic      clock,
  input  logic      clearn,
  input  key_code_t i_keypad,
  input  logic      i_entry_en,
  output bcd_t      o_digit,
  output logic      o_digit_valid,
  output logic      o_shift_c,
  output bcd_t      o_key_bcd_c
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  key_code_t        r_sync1;
  key_code_t        r_sync2;
  kp_state_e        r_state;
  kp_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_cnt_done;
  key_code_t        r_key;
  logic             w_latch;
  logic             w_accept;
  logic             w_shift;
  key_code_t        w_code;
  logic             w_released;
  logic             w_single;
  bcd_t             r_digit;
  logic             r_digit_valid;

  // Two-flop synchronizer for the asynchronous key lines.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_keypad;
      r_sync2 <= r_sync1;
    end
  end

  assign w_code     = r_sync2;
  assign w_released = (w_code == '0);
  assign w_single   = !w_released && ((w_code & (w_code - key_code_t'(1))) == '0);

  // Saturating increment; the last stable sample is the one that lands on DEBOUNCE_CYCLES-1.
  assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_cnt_done = (w_cnt_inc >= CNT_LAST);

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_single) w_state_nxt = ST_PRESS_WAIT;
      end
      ST_PRESS_WAIT: begin
        if (w_code != r_key)  w_state_nxt = ST_IDLE;
        else if (w_cnt_done)  w_state_nxt = ST_HELD;
      end
      ST_HELD: begin
        if (w_released) w_state_nxt = ST_RELEASE_WAIT;
      end
      ST_RELEASE_WAIT: begin
        if (!w_released)     w_state_nxt = ST_HELD;
        else if (w_cnt_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_latch   = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_single) begin
          w_latch   = 1'b1;
          w_cnt_nxt = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (w_code == r_key) begin
          w_cnt_nxt = w_cnt_inc;
          w_accept  = w_cnt_done;
        end
      end
      ST_HELD: begin
        if (w_released) w_cnt_nxt = '0;
      end
      ST_RELEASE_WAIT: begin
        if (w_released) w_cnt_nxt = w_cnt_inc;
      end
      default: w_cnt_nxt = '0;
    endcase
  end

  assign w_shift     = w_accept && i_entry_en;
  assign o_shift_c   = w_shift;
  assign o_key_bcd_c = onehot_to_bcd(r_key);

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      r_cnt         <= '0;
      r_key         <= '0;
      r_digit       <= '0;
      r_digit_valid <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_digit_valid <= w_shift;
      if (w_latch) r_key   <= w_code;
      if (w_shift) r_digit <= o_key_bcd_c;
    end
  end

  assign o_digit       = r_digit;
  assign o_digit_valid = r_digit_valid;

endmodule

// File: rtl/keypad_entry.sv
// Keypad time entry: debounced digits shift into a three-digit BCD time with status flags.
module keypad_entry
  import keypad_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 10
) (
  input  logic           clock,
  input  logic           clearn,
  keypad_entry_if.slave  bus
);

  logic        w_shift_c;
  bcd_t        w_key_bcd_c;
  bcd_t        w_digit;
  logic        w_digit_valid;
  entry_time_t r_time;

  keypad_sync_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clock         (clock),
    .clearn        (clearn),
    .i_keypad      (bus.keypad),
    .i_entry_en    (bus.entry_en),
    .o_digit       (w_digit),
    .o_digit_valid (w_digit_valid),
    .o_shift_c     (w_shift_c),
    .o_key_bcd_c   (w_key_bcd_c)
  );

  // Flush has priority over a same-cycle shift; the oldest digit falls off mins.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      r_time <= '0;
    end else if (bus.flush) begin
      r_time <= '0;
    end else if (w_shift_c) begin
      r_time.mins     <= r_time.sec_tens;
      r_time.sec_tens <= r_time.sec_ones;
      r_time.sec_ones <= w_key_bcd_c;
    end
  end

  assign bus.digit        = w_digit;
  assign bus.digit_valid  = w_digit_valid;
  assign bus.mins         = r_time.mins;
  assign bus.sec_tens     = r_time.sec_tens;
  assign bus.sec_ones     = r_time.sec_ones;
  assign bus.time_nonzero = |r_time;
  assign bus.time_ok      = (r_time.sec_tens <= BCD_W'(5));

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: directed scenarios plus constrained-random presses vs. a run-length model.
module tb_keypad_entry;
  import keypad_entry_pkg::*;

  localparam int unsigned DB = 4;

  logic clock = 1'b0;
  logic clearn;
  always #5 clock = ~clock;

  keypad_entry_if bus();

  keypad_entry #(.DEBOUNCE_CYCLES(DB)) dut (
    .clock  (clock),
    .clearn (clearn),
    .bus    (bus.slave)
  );

  int n_checks = 0;
  int n_err    = 0;
  int n_pulses = 0;

  // Model: keypad delayed two edges, then press/release judged by run lengths.
  logic [9:0] m_p1, m_p2, m_code;
  bit         m_armed;
  int         m_run, m_zrun;
  logic [3:0] m_digit, m_min, m_tens, m_ones;
  bit         m_dv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int key_index(input logic [9:0] c);
    for (int i = 0; i < 10; i++) if (c[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_p1 = '0; m_p2 = '0; m_code = '0;
    m_armed = 1'b1; m_run = 0; m_zrun = 0;
    m_digit = '0; m_dv = 1'b0;
    m_min = '0; m_tens = '0; m_ones = '0;
  endtask

  task automatic model_edge(input logic [9:0] kp, input bit en, input bit fl);
    logic [9:0] used;
    bit acc;
    used = m_p2;
    m_p2 = m_p1;
    m_p1 = kp;
    acc  = 1'b0;
    if (m_armed) begin
      if ($countones(used) == 1) begin
        if (used == m_code && m_run > 0) m_run++;
        else begin
          m_code = used;
          m_run  = 1;
        end
      end else begin
        m_run = 0;
      end
      if (m_run == DB) begin
        acc = 1'b1; m_armed = 1'b0; m_zrun = 0;
      end
    end else begin
      if (used == '0) m_zrun++;
      else            m_zrun = 0;
      if (m_zrun == DB) begin
        m_armed = 1'b1; m_run = 0;
      end
    end
    m_dv = acc && en;
    if (m_dv) m_digit = 4'(key_index(m_code));
    if (fl) begin
      m_min = '0; m_tens = '0; m_ones = '0;
    end else if (m_dv) begin
      m_min = m_tens; m_tens = m_ones; m_ones = m_digit;
    end
  endtask

  task automatic check_outputs();
    chk("digit_valid", 32'(bus.digit_valid), 32'(m_dv));
    chk("digit", 32'(bus.digit), 32'(m_digit));
    chk("mins", 32'(bus.mins), 32'(m_min));
    chk("sec_tens", 32'(bus.sec_tens), 32'(m_tens));
    chk("sec_ones", 32'(bus.sec_ones), 32'(m_ones));
    chk("time_nonzero", 32'(bus.time_nonzero), 32'((m_min | m_tens | m_ones) != 0));
    chk("time_ok", 32'(bus.time_ok), 32'(m_tens <= 4'd5));
  endtask

  task automatic tick(input logic [9:0] kp, input bit en, input bit fl);
    bus.keypad   = kp;
    bus.entry_en = en;
    bus.flush    = fl;
    @(posedge clock);
    model_edge(kp, en, fl);
    #1;
    check_outputs();
    if (bus.digit_valid) n_pulses++;
  endtask

  task automatic hold(input logic [9:0] kp, input bit en, input int n);
    repeat (n) tick(kp, en, 1'b0);
  endtask

  task automatic press(input int k, input bit en);
    logic [9:0] c;
    c = 10'(1) << k;
    hold(c, en, 20);
    hold('0, en, 20);
  endtask

  function automatic logic [9:0] rand_code();
    int a, b;
    a = $urandom_range(0, 9);
    if ($urandom_range(0, 3) != 0) return 10'(1) << a;
    b = (a + $urandom_range(1, 9)) % 10;
    return (10'(1) << a) | (10'(1) << b);
  endfunction

  initial begin
    int p0, lat;
    logic [9:0] c;
    clearn = 1'b0;
    bus.keypad = '0; bus.entry_en = 1'b1; bus.flush = 1'b0;
    model_reset();
    #1;
    chk("rst_digit_valid", 32'(bus.digit_valid), 0);
    chk("rst_time", 32'({bus.mins, bus.sec_tens, bus.sec_ones}), 0);
    chk("rst_time_ok", 32'(bus.time_ok), 1);
    chk("rst_time_nonzero", 32'(bus.time_nonzero), 0);
    #10 clearn = 1'b1;

    // Sequence 2,5,9,9,9: oldest digits discarded from mins.
    p0 = n_pulses;
    press(2, 1'b1); press(5, 1'b1); press(9, 1'b1); press(9, 1'b1); press(9, 1'b1);
    chk("seq_pulses", 32'(n_pulses - p0), 5);
    chk("seq_time", 32'({bus.mins, bus.sec_tens, bus.sec_ones}), 32'h999);
    chk("seq_time_ok", 32'(bus.time_ok), 0);

    // Glitchy key 3 never reaches a full debounce window.
    tick('0, 1'b1, 1'b1);
    p0 = n_pulses;
    for (int i = 0; i < 5; i++) begin
      hold(10'(1) << 3, 1'b1, 3);
      hold('0, 1'b1, 1);
    end
    hold('0, 1'b1, 20);
    chk("glitch_pulses", 32'(n_pulses - p0), 0);
    chk("glitch_time", 32'({bus.mins, bus.sec_tens, bus.sec_ones}), 0);

    // Two keys at once are ignored, then key 7 alone is taken.
    p0 = n_pulses;
    hold(10'b0000100100, 1'b1, 20);
    chk("multi_pulses", 32'(n_pulses - p0), 0);
    hold(10'(1) << 7, 1'b1, 20);
    hold('0, 1'b1, 20);
    chk("multi_then7", 32'(bus.sec_ones), 7);

    // Long hold: no auto-repeat.
    p0 = n_pulses;
    hold(10'(1) << 4, 1'b1, 200);
    hold('0, 1'b1, 20);
    chk("long_hold_pulses", 32'(n_pulses - p0), 1);

    // Entry disabled: nothing shifts.
    tick('0, 1'b1, 1'b1);
    p0 = n_pulses;
    press(1, 1'b0);
    chk("dis_pulses", 32'(n_pulses - p0), 0);
    chk("dis_time", 32'({bus.mins, bus.sec_tens, bus.sec_ones}), 0);

    // Flush coinciding with acceptance of key 6.
    press(3, 1'b1);
    p0 = n_pulses;
    for (int i = 0; i < 20; i++) tick(10'(1) << 6, 1'b1, (i == 5));
    hold('0, 1'b1, 20);
    chk("flush_acc_pulses", 32'(n_pulses - p0), 1);
    chk("flush_acc_digit", 32'(bus.digit), 6);
    chk("flush_acc_time", 32'({bus.mins, bus.sec_tens, bus.sec_ones}), 0);

    // Reset mid-debounce of key 8 discards it; full debounce needed afterwards.
    press(5, 1'b1);
    hold(10'(1) << 8, 1'b1, 4);
    clearn = 1'b0;
    #1;
    model_reset();
    chk("midrst_digit", 32'(bus.digit), 0);
    chk("midrst_time", 32'({bus.mins, bus.sec_tens, bus.sec_ones}), 0);
    chk("midrst_time_ok", 32'(bus.time_ok), 1);
    #10 clearn = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      tick(10'(1) << 8, 1'b1, 1'b0);
      lat++;
      if (bus.digit_valid) break;
    end
    chk("midrst_latency", 32'(lat), DB + 2);
    chk("midrst_ones", 32'(bus.sec_ones), 8);
    hold('0, 1'b1, 20);

    // Constrained random: nonzero segments separated by released gaps.
    for (int s = 0; s < 250; s++) begin
      c = rand_code();
      repeat ($urandom_range(1, 3 * DB))
        tick(c, ($urandom_range(0, 4) != 0), ($urandom_range(0, 19) == 0));
      repeat ($urandom_range(1, 2 * DB))
        tick('0, ($urandom_range(0, 4) != 0), ($urandom_range(0, 19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
